spi_master_ctrl: RTL and testbench

Host-side SPI master that generates frames for the on-chip SPI slave/RAM interface. It sits directly upstream of the slave: it converts single host commands (opcode + byte) into SS_n/MOSI frames and, for read-data commands, captures the 8-bit MISO reply and returns it to the host. Master and slave share `clk` as the serial clock. All SPI-side outputs are registered.

---
 rtl/spi_master_ctrl_if.sv | 22 ++
 rtl/spi_master_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_ctrl_if.sv
// Host command/response bundle for spi_master_ctrl.
// master = host side, slave = the controller.
interface spi_master_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       err;
    logic       busy;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, err, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, err, busy
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master: turns host opcode+byte commands into SS_n/MOSI frames
// and captures the 8-bit MISO reply of read-data frames.
module spi_master_ctrl #(
    parameter int READ_LATENCY = 2,
    parameter int TAIL_CYCLES  = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_master_ctrl_if.slave      host,
    output logic                  o_ss_n,
    output logic                  o_mosi,
    input  logic                  i_miso
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SHIFT,
        S_TAIL,
        S_WAIT,
        S_CAPTURE,
        S_GAP
    } state_t;

    localparam logic [4:0] SHIFT_LOAD = 5'd10;
    localparam logic [4:0] CAP_LOAD   = 5'd7;
    localparam logic [4:0] WAIT_LOAD  = 5'(READ_LATENCY - 1);
    localparam logic [4:0] TAIL_LOAD  = 5'(TAIL_CYCLES - 1);
    localparam logic [4:0] GAP_LOAD   = 5'(GAP_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_cnt;
    logic [4:0]  w_cnt_nxt;
    logic [10:0] r_frame;
    logic [10:0] w_frame_nxt;
    logic [7:0]  r_rx;
    logic [7:0]  w_rx_nxt;
    logic [7:0]  r_rsp_data;
    logic [7:0]  w_rsp_data_nxt;
    logic        r_rsp_valid;
    logic        w_rsp_valid_nxt;
    logic        r_err;
    logic        w_err_nxt;
    logic        r_ready;
    logic        w_ready_nxt;
    logic        r_busy;
    logic        w_busy_nxt;
    logic        r_ss_n;
    logic        w_ss_n_nxt;
    logic        r_mosi;
    logic        w_mosi_nxt;
    logic        r_rd_pend;
    logic        w_rd_pend_nxt;

    logic        w_accept;
    logic        w_cnt_done;
    logic        w_rd_data;
    logic [7:0]  w_rx_shift;

    assign w_accept   = r_ready && host.cmd_valid;
    assign w_cnt_done = (r_cnt == 5'd0);
    assign w_rd_data  = (r_frame[9:8] == 2'b11);
    assign w_rx_shift = {r_rx[6:0], i_miso};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 5'd0;
            r_frame     <= 11'd0;
            r_rx        <= 8'd0;
            r_rsp_data  <= 8'd0;
            r_rsp_valid <= 1'b0;
            r_err       <= 1'b0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_ss_n      <= 1'b1;
            r_mosi      <= 1'b0;
            r_rd_pend   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_frame     <= w_frame_nxt;
            r_rx        <= w_rx_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_err       <= w_err_nxt;
            r_ready     <= w_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_ss_n      <= w_ss_n_nxt;
            r_mosi      <= w_mosi_nxt;
            r_rd_pend   <= w_rd_pend_nxt;
        end
    end

    // SPI pins are registered, so they show the state of the previous cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_frame_nxt     = r_frame;
        w_rx_nxt        = r_rx;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_valid_nxt = 1'b0;
        w_err_nxt       = 1'b0;
        w_ready_nxt     = r_ready;
        w_busy_nxt      = r_busy;
        w_ss_n_nxt      = 1'b0;
        w_mosi_nxt      = 1'b0;
        w_rd_pend_nxt   = r_rd_pend;

        unique case (r_state)
            S_IDLE: begin
                w_ss_n_nxt = 1'b1;
                if (w_accept) begin
                    w_frame_nxt = {host.cmd_op[1], host.cmd_op, host.cmd_data};
                    w_state_nxt = S_START;
                    w_cnt_nxt   = 5'd0;
                    w_ss_n_nxt  = 1'b0;
                    w_ready_nxt = 1'b0;
                    w_busy_nxt  = 1'b1;
                    unique case (host.cmd_op)
                        2'b10:   w_rd_pend_nxt = 1'b1;
                        2'b11: begin
                            w_rd_pend_nxt = 1'b0;
                            w_err_nxt     = !r_rd_pend;
                        end
                        default: w_rd_pend_nxt = r_rd_pend;
                    endcase
                end
            end

            S_START: begin
                w_state_nxt = S_SHIFT;
                w_cnt_nxt   = SHIFT_LOAD;
            end

            S_SHIFT: begin
                w_mosi_nxt = r_frame[r_cnt[3:0]];
                if (w_cnt_done) begin
                    if (w_rd_data) begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = WAIT_LOAD;
                    end else begin
                        w_state_nxt = S_TAIL;
                        w_cnt_nxt   = TAIL_LOAD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 5'd1;
                end
            end

            S_TAIL: begin
                if (w_cnt_done) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = GAP_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - 5'd1;
                end
            end

            S_WAIT: begin
                if (w_cnt_done) begin
                    w_state_nxt = S_CAPTURE;
                    w_cnt_nxt   = CAP_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - 5'd1;
                end
            end

            S_CAPTURE: begin
                w_rx_nxt = w_rx_shift;
                if (w_cnt_done) begin
                    w_rsp_data_nxt  = w_rx_shift;
                    w_rsp_valid_nxt = 1'b1;
                    w_ss_n_nxt      = 1'b1;
                    w_state_nxt     = S_GAP;
                    w_cnt_nxt       = GAP_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - 5'd1;
                end
            end

            S_GAP: begin
                w_ss_n_nxt = 1'b1;
                if (w_cnt_done) begin
                    w_state_nxt = S_IDLE;
                    w_ready_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - 5'd1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_ss_n_nxt  = 1'b1;
                w_ready_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign host.cmd_ready = r_ready;
    assign host.rsp_valid = r_rsp_valid;
    assign host.rsp_data  = r_rsp_data;
    assign host.err       = r_err;
    assign host.busy      = r_busy;
    assign o_ss_n         = r_ss_n;
    assign o_mosi         = r_mosi;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl with a behavioural SPI slave/RAM.
// Driver pushes expected frames/responses; negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_spi_master_ctrl;
    localparam int RL = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic miso  = 1'b0;
    logic ss_n;
    logic mosi;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   m_pend = 1'b0;

    typedef struct {
        int          len;
        logic [10:0] word;
        bit          chk_word;
    } frame_exp_t;

    typedef struct {
        logic [7:0] data;
        int         at;
    } rsp_exp_t;

    frame_exp_t q_frame[$];
    rsp_exp_t   q_rsp[$];
    int         q_err[$];

    spi_master_ctrl_if host_if();

    spi_master_ctrl #(
        .READ_LATENCY(2),
        .TAIL_CYCLES (2),
        .GAP_CYCLES  (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .host  (host_if),
        .o_ss_n(ss_n),
        .o_mosi(mosi),
        .i_miso(miso)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got pulse/frame, expected none (cycle %0d)",
                 name, cyc);
    endtask

    // Slave model and monitor
    logic [7:0]  ram [256];
    logic [7:0]  s_addr  = 8'h00;
    logic [7:0]  s_rd    = 8'h00;
    logic [10:0] s_word  = '0;
    bit          s_stray = 1'b0;
    bit          in_frame = 1'b0;
    int          fj = 0;
    logic [2:0]  bi;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    end

    always @(negedge clk) begin
        frame_exp_t fe;
        rsp_exp_t   re;
        int         ea;
        if (!ss_n) begin
            if (!in_frame) begin
                in_frame = 1'b1;
                fj       = 0;
                s_word   = '0;
                s_stray  = 1'b0;
            end
            if (fj >= 2 && fj <= 12) s_word = {s_word[9:0], mosi};
            else if (mosi) s_stray = 1'b1;
            if (fj == 12) begin
                case (s_word[9:8])
                    2'b00: s_addr = s_word[7:0];
                    2'b01: ram[s_addr] = s_word[7:0];
                    2'b10: s_addr = s_word[7:0];
                    2'b11: s_rd = ram[s_addr];
                    default: ;
                endcase
            end
            if (fj >= 12 + RL && fj <= 19 + RL) begin
                bi   = 3'(19 + RL - fj);
                miso = s_rd[bi];
            end else begin
                miso = 1'b0;
            end
            fj++;
        end else begin
            miso = 1'b0;
            if (in_frame) begin
                in_frame = 1'b0;
                if (q_frame.size() == 0) unexpected("frame");
                else begin
                    fe = q_frame.pop_front();
                    chk("ss_low_len", 32'(fj), 32'(fe.len));
                    if (fe.chk_word)
                        chk("mosi_frame", 32'({s_stray, s_word}),
                            32'({1'b0, fe.word}));
                end
            end
        end

        if (host_if.rsp_valid) begin
            if (q_rsp.size() == 0) unexpected("rsp_valid");
            else begin
                re = q_rsp.pop_front();
                chk("rsp_data", 32'(host_if.rsp_data), 32'(re.data));
                chk("rsp_cycle", 32'(cyc), 32'(re.at));
            end
        end

        if (host_if.err) begin
            if (q_err.size() == 0) unexpected("err");
            else begin
                ea = q_err.pop_front();
                chk("err_cycle", 32'(cyc), 32'(ea));
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] d,
                        input logic [10:0] word, input int len,
                        input logic [7:0] rsp, input bit keep,
                        output int acc);
        int n;
        frame_exp_t fe;
        rsp_exp_t   re;
        n = 0;
        @(negedge clk);
        host_if.cmd_valid = 1'b1;
        host_if.cmd_op    = op;
        host_if.cmd_data  = d;
        while (!host_if.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 200), 32'd1);
        acc         = cyc + 1;
        fe.len      = len;
        fe.word     = word;
        fe.chk_word = (len >= 15);
        q_frame.push_back(fe);
        if (op == 2'b11) begin
            re.data = rsp;
            re.at   = acc + 20 + RL;
            q_rsp.push_back(re);
            if (!m_pend) q_err.push_back(acc);
            m_pend = 1'b0;
        end else if (op == 2'b10) begin
            m_pend = 1'b1;
        end
        @(negedge clk);
        if (!keep) host_if.cmd_valid = 1'b0;
        chk("busy_after_accept", 32'(host_if.busy), 32'd1);
        chk("ready_after_accept", 32'(host_if.cmd_ready), 32'd0);
    endtask

    initial begin
        int a0;
        int a1;
        int a2;
        int a3;
        int n;
        host_if.cmd_valid = 1'b0;
        host_if.cmd_op    = 2'b00;
        host_if.cmd_data  = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_ss_n", 32'(ss_n), 32'd1);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_ready", 32'(host_if.cmd_ready), 32'd1);
        chk("rst_busy", 32'(host_if.busy), 32'd0);
        chk("rst_rsp_valid", 32'(host_if.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(host_if.rsp_data), 32'd0);
        chk("rst_err", 32'(host_if.err), 32'd0);
        rst_n = 1'b1;

        send(2'b00, 8'h3C, 11'h03C, 15, 8'h00, 1'b0, a0);
        wait_until(a0 + 14);
        chk("wa_ss_low_end", 32'(ss_n), 32'd0);
        chk("wa_ready_low", 32'(host_if.cmd_ready), 32'd0);
        @(negedge clk);
        chk("wa_ss_rise", 32'(ss_n), 32'd1);
        @(negedge clk);
        chk("wa_ready_back", 32'(host_if.cmd_ready), 32'd1);
        chk("wa_busy_clear", 32'(host_if.busy), 32'd0);

        send(2'b00, 8'h10, 11'h010, 15, 8'h00, 1'b0, a0);
        send(2'b01, 8'hA7, 11'h1A7, 15, 8'h00, 1'b0, a0);
        send(2'b00, 8'h20, 11'h020, 15, 8'h00, 1'b0, a0);
        send(2'b01, 8'hA5, 11'h1A5, 15, 8'h00, 1'b0, a0);
        send(2'b10, 8'h20, 11'h620, 15, 8'h00, 1'b0, a0);
        send(2'b11, 8'h00, 11'h700, 22, 8'hA5, 1'b0, a0);
        send(2'b10, 8'h10, 11'h610, 15, 8'h00, 1'b0, a0);
        send(2'b11, 8'h5A, 11'h75A, 22, 8'hA7, 1'b0, a0);
        send(2'b11, 8'h00, 11'h700, 22, 8'hA7, 1'b0, a0);

        send(2'b00, 8'h55, 11'h055, 15, 8'h00, 1'b1, a1);
        send(2'b00, 8'h55, 11'h055, 15, 8'h00, 1'b1, a2);
        send(2'b00, 8'h55, 11'h055, 15, 8'h00, 1'b1, a3);
        host_if.cmd_valid = 1'b0;
        chk("accept_interval_1", 32'(a2 - a1), 32'd17);
        chk("accept_interval_2", 32'(a3 - a2), 32'd17);

        send(2'b10, 8'h20, 11'h620, 15, 8'h00, 1'b0, a0);
        send(2'b00, 8'h33, 11'h033, 6, 8'h00, 1'b0, a0);
        wait_until(a0 + 5);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ss_n", 32'(ss_n), 32'd1);
        chk("midrst_mosi", 32'(mosi), 32'd0);
        chk("midrst_ready", 32'(host_if.cmd_ready), 32'd1);
        chk("midrst_busy", 32'(host_if.busy), 32'd0);
        rst_n  = 1'b1;
        m_pend = 1'b0;
        send(2'b11, 8'h00, 11'h700, 22, 8'hA5, 1'b0, a0);

        n = 0;
        while ((q_frame.size() != 0 || q_rsp.size() != 0 ||
                q_err.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        chk("frame_queue_empty", 32'(q_frame.size()), 32'd0);
        chk("rsp_queue_empty", 32'(q_rsp.size()), 32'd0);
        chk("err_queue_empty", 32'(q_err.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
